wb_write_queue: RTL and testbench

//  Write-side driver for the CPU register file: merges ALU and memory (load) writeback

---
 rtl/wb_write_queue.sv | 120 ++++++++++++
 tb/tb_wb_write_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: regfile write-port arbiter, ALU first, loads queued in order.
// Define WBQ_BYPASS_EN to add decode bypass lookup of pending writes.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          rf_wr,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  output logic          q_empty,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          byp_hit1,
  output logic [DW-1:0] byp_data1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             alu_acc;
  logic             push;
  logic             pop;

  assign mem_ready = (count != CW'(DEPTH)) & reset;
  assign alu_acc   = alu_valid & (alu_addr != '0);
  assign push      = mem_valid & mem_ready & (mem_addr != '0);
  assign pop       = ~alu_acc & (count != '0);
  assign q_empty   = ~|q_vld;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q_vld   <= '0;
      rf_wr   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      if (alu_acc) begin
        rf_wr   <= 1'b1;
        rf_addr <= alu_addr;
        rf_data <= alu_data;
        // older queued loads to this register must never land after it
        for (int i = 0; i < DEPTH; i++)
          if (q_addr[i] == alu_addr) q_vld[i] <= 1'b0;
      end else if (pop) begin
        rf_wr         <= q_vld[rd_ptr];
        rf_addr       <= q_addr[rd_ptr];
        rf_data       <= q_data[rd_ptr];
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end else begin
        rf_wr <= 1'b0;
      end
      if (push) begin
        q_vld[wr_ptr]  <= 1'b1;
        q_addr[wr_ptr] <= mem_addr;
        q_data[wr_ptr] <= mem_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [DW:0]   byp1;
  logic [DW:0]   byp2;
  logic [PW-1:0] idx;

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    byp1 = '0;
    byp2 = '0;
    idx  = '0;
    if (rf_wr && rf_addr == rd_addr1) byp1 = {1'b1, rf_data};
    if (rf_wr && rf_addr == rd_addr2) byp2 = {1'b1, rf_data};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (q_vld[idx] && q_addr[idx] == rd_addr1)
        byp1 = {1'b1, q_data[idx]};
      if (q_vld[idx] && q_addr[idx] == rd_addr2)
        byp2 = {1'b1, q_data[idx]};
    end
    if (rd_addr1 == '0) byp1 = '0;
    if (rd_addr2 == '0) byp2 = '0;
  end

  assign byp_hit1  = byp1[DW];
  assign byp_data1 = byp1[DW-1:0];
  assign byp_hit2  = byp2[DW];
  assign byp_data2 = byp2[DW-1:0];
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_data1 = '0;
  assign byp_hit2  = 1'b0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed scenarios plus random traffic vs a queue model.
// Bypass expectations follow WBQ_BYPASS_EN when defined.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          valid;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        q_empty;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic        byp_hit2;
  logic [31:0] byp_data2;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        mq[$];
  bit          m_wr   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .q_empty(q_empty),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return reset && (mq.size() != DEPTH);
  endfunction

  function automatic bit exp_empty();
    foreach (mq[i]) if (mq[i].valid) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [32:0] exp_byp(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef WBQ_BYPASS_EN
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].valid && mq[i].addr == a) return {1'b1, mq[i].data};
    if (m_wr && m_addr == a) return {1'b1, m_data};
`endif
    return '0;
  endfunction

  // advance one clock and update the model with the inputs seen at that edge
  task automatic step();
    bit   acc;
    bit   aacc;
    ent_t e;
    acc  = exp_ready() && mem_valid;
    aacc = alu_valid && alu_addr != 0;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (aacc) begin
        foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].valid = 1'b0;
        m_wr = 1'b1; m_addr = alu_addr; m_data = alu_data;
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        m_wr = e.valid; m_addr = e.addr; m_data = e.data;
      end else begin
        m_wr = 1'b0;
      end
      if (acc && mem_addr != 0) begin
        e.addr = mem_addr; e.data = mem_data; e.valid = 1'b1;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_tests++;
    if ({rf_wr, rf_addr, rf_data} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_rf: got %b/%0d/%h want 0/0/0", rf_wr, rf_addr, rf_data);
    end
    n_tests++;
    if ({q_empty, mem_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_flags: q_empty=%b mem_ready=%b want 1/0", q_empty, mem_ready);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", mem_ready);
    end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
    step();
    alu_valid = 1'b0;
    n_tests++;
    if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'd5, 32'h11}) begin
      n_fail++;
      $display("FAIL alu_write: got %b/%0d/%h want 1/5/11", rf_wr, rf_addr, rf_data);
    end
    step();
    n_tests++;
    if (rf_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_idle: rf_wr got %b want 0", rf_wr);
    end
  endtask

  task automatic test_fill_drain();
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    for (int k = 1; k <= 4; k++) begin
      mem_valid = 1'b1; mem_addr = 5'(k); mem_data = 32'h9 + 32'(k);
      n_tests++;
      if (mem_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready%0d: got %b want 1", k, mem_ready);
      end
      step();
    end
    mem_valid = 1'b0;
    n_tests++;
    if (mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: mem_ready got %b want 0", mem_ready);
    end
    alu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'(k), 32'h9 + 32'(k)}) begin
        n_fail++;
        $display("FAIL drain%0d: got %b/%0d/%h want 1/%0d/%h",
                 k, rf_wr, rf_addr, rf_data, k, 32'h9 + 32'(k));
      end
    end
    n_tests++;
    if (q_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: q_empty got %b want 1", q_empty);
    end
    step();
    n_tests++;
    if (rf_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: rf_wr got %b want 0", rf_wr);
    end
  endtask

  task automatic test_kill();
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h70;
    step();
    mem_valid = 1'b0;
    alu_addr = 5'd7; alu_data = 32'h77;
    step();
    n_tests++;
    if ({rf_wr, rf_addr, rf_data, q_empty} !== {1'b1, 5'd7, 32'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL kill_alu: got %b/%0d/%h empty=%b want 1/7/77 empty=1",
               rf_wr, rf_addr, rf_data, q_empty);
    end
    alu_valid = 1'b0;
    step();
    n_tests++;
    if (rf_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_pop: rf_wr got %b want 0", rf_wr);
    end
    step();
    n_tests++;
    if ({rf_wr, mem_ready, q_empty} !== 3'b011) begin
      n_fail++;
      $display("FAIL kill_after: wr/ready/empty got %b%b%b want 011",
               rf_wr, mem_ready, q_empty);
    end
  endtask

  task automatic test_zero_addr();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBEEF;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({rf_wr, q_empty, mem_ready} !== 3'b011) begin
        n_fail++;
        $display("FAIL zero_addr%0d: wr/empty/ready got %b%b%b want 011",
                 k, rf_wr, q_empty, mem_ready);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_addr = 5'(10 + k); mem_data = 32'h100 + 32'(k);
      step();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    reset = 1'b0;
    step();
    n_tests++;
    if ({rf_wr, q_empty, mem_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_mid: wr/empty/ready got %b%b%b want 010",
               rf_wr, q_empty, mem_ready);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b want 1", mem_ready);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (rf_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_stale%0d: rf_wr got %b want 0", k, rf_wr);
      end
    end
  endtask

  task automatic test_bypass();
    logic [32:0] w1;
    logic [32:0] w2;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h1;
    step();
    mem_data = 32'h2;
    step();
    mem_valid = 1'b0;
    rd_addr1 = 5'd3; rd_addr2 = 5'd9;
    #1;
`ifdef WBQ_BYPASS_EN
    w1 = {1'b1, 32'h2};
    w2 = {1'b1, 32'h99};
`else
    w1 = '0;
    w2 = '0;
`endif
    n_tests++;
    if ({byp_hit1, byp_data1} !== w1) begin
      n_fail++;
      $display("FAIL byp_queue: got %b/%h want %b/%h", byp_hit1, byp_data1, w1[32], w1[31:0]);
    end
    n_tests++;
    if ({byp_hit2, byp_data2} !== w2) begin
      n_fail++;
      $display("FAIL byp_rf: got %b/%h want %b/%h", byp_hit2, byp_data2, w2[32], w2[31:0]);
    end
    alu_valid = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_random();
    logic [32:0] b1;
    logic [32:0] b2;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 49) != 0);
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 9) < 6);
      mem_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      rd_addr1  = 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 7));
      #1;
      b1 = exp_byp(rd_addr1);
      b2 = exp_byp(rd_addr2);
      n_tests++;
      if ({mem_ready, q_empty} !== {exp_ready(), exp_empty()}) begin
        n_fail++;
        $display("FAIL rnd_flags c%0d: ready/empty got %b%b want %b%b",
                 c, mem_ready, q_empty, exp_ready(), exp_empty());
      end
      n_tests++;
      if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== {b1, b2}) begin
        n_fail++;
        $display("FAIL rnd_byp c%0d: got %b/%h %b/%h want %b/%h %b/%h", c,
                 byp_hit1, byp_data1, byp_hit2, byp_data2,
                 b1[32], b1[31:0], b2[32], b2[31:0]);
      end
      step();
      n_tests++;
      if ({rf_wr, rf_addr, rf_data} !== {m_wr, m_addr, m_data}) begin
        n_fail++;
        $display("FAIL rnd_rf c%0d: got %b/%0d/%h want %b/%0d/%h",
                 c, rf_wr, rf_addr, rf_data, m_wr, m_addr, m_data);
      end
    end
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fill_drain();
    test_kill();
    test_zero_addr();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
